// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store with LSU priority,
// a streak limit that guarantees fetch progress, and a watchdog on the response wait.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid_i,
    output logic                ifu_req_ready_o,
    input  logic [ADDR_W-1:0]   ifu_req_addr_i,
    output logic                ifu_rsp_valid_o,
    output logic [DATA_W-1:0]   ifu_rsp_data_o,
    output logic                ifu_rsp_err_o,

    input  logic                lsu_req_valid_i,
    output logic                lsu_req_ready_o,
    input  logic [ADDR_W-1:0]   lsu_req_addr_i,
    input  logic                lsu_req_wen_i,
    input  logic [DATA_W-1:0]   lsu_req_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_req_wmask_i,
    output logic                lsu_rsp_valid_o,
    output logic [DATA_W-1:0]   lsu_rsp_data_o,
    output logic                lsu_rsp_err_o,

    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    output logic                mem_req_wen_o,
    output logic [DATA_W-1:0]   mem_req_wdata_o,
    output logic [DATA_W/8-1:0] mem_req_wmask_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_W-1:0]   mem_rsp_data_i,

    output logic                busy_o
);
    localparam int MASK_W   = DATA_W / 8;
    localparam int CNT_W    = $clog2(TIMEOUT);
    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                mem_valid_q, mem_valid_d;
    logic                busy_q, busy_d;
    logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
    logic [DATA_W-1:0]   ifu_rsp_data_q, ifu_rsp_data_d;
    logic                ifu_rsp_err_q, ifu_rsp_err_d;
    logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
    logic [DATA_W-1:0]   lsu_rsp_data_q, lsu_rsp_data_d;
    logic                lsu_rsp_err_q, lsu_rsp_err_d;

    logic                lsu_wins, lsu_grant, ifu_grant;
    logic                rsp_fire, rsp_err;
    logic [DATA_W-1:0]   rsp_data;

    // Grants are a pure function of the valids and the streak, never of ready itself.
    assign lsu_wins  = lsu_req_valid_i && ((streak_q < STREAK_MAX) || !ifu_req_valid_i);
    assign lsu_grant = (state_q == S_IDLE) && lsu_wins;
    assign ifu_grant = (state_q == S_IDLE) && ifu_req_valid_i && !lsu_wins;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        rsp_fire = 1'b0;
        rsp_err  = 1'b0;
        rsp_data = '0;

        case (state_q)
            S_IDLE: begin
                if (lsu_grant) begin
                    state_d = S_REQ;
                    owner_d = OWN_LSU;
                    addr_d  = lsu_req_addr_i;
                    wen_d   = lsu_req_wen_i;
                    wdata_d = lsu_req_wdata_i;
                    wmask_d = lsu_req_wmask_i;
                    if (ifu_req_valid_i && (streak_q < STREAK_MAX)) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (ifu_grant) begin
                    state_d  = S_REQ;
                    owner_d  = OWN_IFU;
                    addr_d   = ifu_req_addr_i;
                    wen_d    = 1'b0;
                    wdata_d  = '0;
                    wmask_d  = '0;
                    streak_d = '0;
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // A response arriving on the last allowed cycle beats the watchdog.
                if (mem_rsp_valid_i) begin
                    state_d  = S_IDLE;
                    rsp_fire = 1'b1;
                    rsp_data = mem_rsp_data_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_IDLE;
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        mem_valid_d     = (state_d == S_REQ);
        busy_d          = (state_d != S_IDLE);
        ifu_rsp_valid_d = rsp_fire && (owner_q == OWN_IFU);
        lsu_rsp_valid_d = rsp_fire && (owner_q == OWN_LSU);
        ifu_rsp_data_d  = ifu_rsp_valid_d ? rsp_data : ifu_rsp_data_q;
        ifu_rsp_err_d   = ifu_rsp_valid_d ? rsp_err  : ifu_rsp_err_q;
        lsu_rsp_data_d  = lsu_rsp_valid_d ? rsp_data : lsu_rsp_data_q;
        lsu_rsp_err_d   = lsu_rsp_valid_d ? rsp_err  : lsu_rsp_err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            owner_q         <= OWN_IFU;
            streak_q        <= '0;
            cnt_q           <= '0;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            mem_valid_q     <= 1'b0;
            busy_q          <= 1'b0;
            ifu_rsp_valid_q <= 1'b0;
            ifu_rsp_data_q  <= '0;
            ifu_rsp_err_q   <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
            lsu_rsp_data_q  <= '0;
            lsu_rsp_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            streak_q        <= streak_d;
            cnt_q           <= cnt_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            mem_valid_q     <= mem_valid_d;
            busy_q          <= busy_d;
            ifu_rsp_valid_q <= ifu_rsp_valid_d;
            ifu_rsp_data_q  <= ifu_rsp_data_d;
            ifu_rsp_err_q   <= ifu_rsp_err_d;
            lsu_rsp_valid_q <= lsu_rsp_valid_d;
            lsu_rsp_data_q  <= lsu_rsp_data_d;
            lsu_rsp_err_q   <= lsu_rsp_err_d;
        end
    end

    assign ifu_req_ready_o = ifu_grant;
    assign lsu_req_ready_o = lsu_grant;
    assign ifu_rsp_valid_o = ifu_rsp_valid_q;
    assign ifu_rsp_data_o  = ifu_rsp_data_q;
    assign ifu_rsp_err_o   = ifu_rsp_err_q;
    assign lsu_rsp_valid_o = lsu_rsp_valid_q;
    assign lsu_rsp_data_o  = lsu_rsp_data_q;
    assign lsu_rsp_err_o   = lsu_rsp_err_q;
    assign mem_req_valid_o = mem_valid_q;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_wen_o   = wen_q;
    assign mem_req_wdata_o = wdata_q;
    assign mem_req_wmask_o = wmask_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors and corner sequences, then
// randomized traffic compared against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int MS = 4;
    localparam int TO = 8;

    logic          clk;
    logic          rst;
    logic          ifu_req_valid_i, ifu_req_ready_o;
    logic [AW-1:0] ifu_req_addr_i;
    logic          ifu_rsp_valid_o, ifu_rsp_err_o;
    logic [DW-1:0] ifu_rsp_data_o;
    logic          lsu_req_valid_i, lsu_req_ready_o, lsu_req_wen_i;
    logic [AW-1:0] lsu_req_addr_i;
    logic [DW-1:0] lsu_req_wdata_i;
    logic [MW-1:0] lsu_req_wmask_i;
    logic          lsu_rsp_valid_o, lsu_rsp_err_o;
    logic [DW-1:0] lsu_rsp_data_o;
    logic          mem_req_valid_o, mem_req_ready_i, mem_req_wen_o;
    logic [AW-1:0] mem_req_addr_o;
    logic [DW-1:0] mem_req_wdata_o;
    logic [MW-1:0] mem_req_wmask_o;
    logic          mem_rsp_valid_i;
    logic [DW-1:0] mem_rsp_data_i;
    logic          busy_o;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
        .ifu_req_addr_i(ifu_req_addr_i), .ifu_rsp_valid_o(ifu_rsp_valid_o),
        .ifu_rsp_data_o(ifu_rsp_data_o), .ifu_rsp_err_o(ifu_rsp_err_o),
        .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_req_addr_i(lsu_req_addr_i), .lsu_req_wen_i(lsu_req_wen_i),
        .lsu_req_wdata_i(lsu_req_wdata_i), .lsu_req_wmask_i(lsu_req_wmask_i),
        .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_data_o(lsu_rsp_data_o),
        .lsu_rsp_err_o(lsu_rsp_err_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_wen_o(mem_req_wen_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wmask_o(mem_req_wmask_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic iv;
        logic lv;
        logic exp_ir;
        logic exp_lr;
    } arb_vec_t;

    // Reference model state: one open transaction described by its owner,
    // latched fields and the cycle at which its wait phase started.
    bit            m_open;
    bit            m_owner_lsu;
    int            m_wait_start;
    int            m_streak;
    int            m_t;
    logic [AW-1:0] m_addr;
    logic          m_wen;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;
    bit            m_pulse_ifu, m_pulse_lsu;
    logic [DW-1:0] m_ifu_data, m_lsu_data;
    logic          m_ifu_err, m_lsu_err;
    bit            m_lsu_store_rsp;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [AW-1:0] ia,
                                 input logic lv, input logic [AW-1:0] la, input logic lw,
                                 input logic [DW-1:0] ld, input logic [MW-1:0] lm);
        ifu_req_valid_i = iv;
        ifu_req_addr_i  = ia;
        lsu_req_valid_i = lv;
        lsu_req_addr_i  = la;
        lsu_req_wen_i   = lw;
        lsu_req_wdata_i = ld;
        lsu_req_wmask_i = lm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at the drive slot or mid-cycle of a REQ cycle with mem_req_ready_i high;
    // returns at the drive slot of the cycle showing the response pulse.
    task automatic serveTxn(input logic [DW-1:0] data);
        tick();
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = data;
        tick();
        mem_rsp_valid_i = 1'b0;
    endtask

    task automatic modelReset();
        m_open = 0; m_owner_lsu = 0; m_wait_start = -1; m_streak = 0; m_t = 0;
        m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
        m_pulse_ifu = 0; m_pulse_lsu = 0;
        m_ifu_data = '0; m_lsu_data = '0; m_ifu_err = 0; m_lsu_err = 0;
        m_lsu_store_rsp = 0;
    endtask

    task automatic modelFinish(input logic err, input logic [DW-1:0] data);
        m_open = 0;
        if (m_owner_lsu) begin
            m_pulse_lsu = 1; m_lsu_err = err; m_lsu_data = data;
            m_lsu_store_rsp = m_wen && !err;
        end else begin
            m_pulse_ifu = 1; m_ifu_err = err; m_ifu_data = data;
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the edge.
    task automatic modelStep();
        bit e_lr, e_ir, in_req;
        e_lr   = !m_open && lsu_req_valid_i && (m_streak < MS || !ifu_req_valid_i);
        e_ir   = !m_open && ifu_req_valid_i && !e_lr;
        in_req = m_open && (m_wait_start < 0);
        checkOutput("rnd ifu_ready", ifu_req_ready_o, e_ir);
        checkOutput("rnd lsu_ready", lsu_req_ready_o, e_lr);
        checkOutput("rnd mem_valid", mem_req_valid_o, in_req);
        checkOutput("rnd busy", busy_o, m_open);
        checkOutput("rnd ifu_rsp_valid", ifu_rsp_valid_o, m_pulse_ifu);
        checkOutput("rnd lsu_rsp_valid", lsu_rsp_valid_o, m_pulse_lsu);
        if (in_req) begin
            checkOutput("rnd mem_addr", mem_req_addr_o, m_addr);
            checkOutput("rnd mem_wen", mem_req_wen_o, m_wen);
            checkOutput("rnd mem_wdata", mem_req_wdata_o, m_wdata);
            checkOutput("rnd mem_wmask", mem_req_wmask_o, m_wmask);
        end
        if (m_pulse_ifu) begin
            checkOutput("rnd ifu_err", ifu_rsp_err_o, m_ifu_err);
            checkOutput("rnd ifu_data", ifu_rsp_data_o, m_ifu_data);
        end
        if (m_pulse_lsu) begin
            checkOutput("rnd lsu_err", lsu_rsp_err_o, m_lsu_err);
            if (!m_lsu_store_rsp) checkOutput("rnd lsu_data", lsu_rsp_data_o, m_lsu_data);
        end

        m_pulse_ifu = 0;
        m_pulse_lsu = 0;
        if (!m_open) begin
            if (e_lr) begin
                m_open = 1; m_owner_lsu = 1; m_wait_start = -1;
                m_addr = lsu_req_addr_i; m_wen = lsu_req_wen_i;
                m_wdata = lsu_req_wdata_i; m_wmask = lsu_req_wmask_i;
                if (ifu_req_valid_i) m_streak = (m_streak + 1 > MS) ? MS : m_streak + 1;
            end else if (e_ir) begin
                m_open = 1; m_owner_lsu = 0; m_wait_start = -1;
                m_addr = ifu_req_addr_i; m_wen = 0; m_wdata = '0; m_wmask = '0;
                m_streak = 0;
            end
        end else if (m_wait_start < 0) begin
            if (mem_req_ready_i) m_wait_start = m_t + 1;
        end else begin
            if (mem_rsp_valid_i) modelFinish(1'b0, mem_rsp_data_i);
            else if (m_t - m_wait_start + 1 == TO) modelFinish(1'b1, '0);
        end
        m_t++;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " ifu_ready"}, ifu_req_ready_o, 0);
        checkOutput({tag, " lsu_ready"}, lsu_req_ready_o, 0);
        checkOutput({tag, " mem_valid"}, mem_req_valid_o, 0);
        checkOutput({tag, " mem_addr"}, mem_req_addr_o, 0);
        checkOutput({tag, " mem_wen"}, mem_req_wen_o, 0);
        checkOutput({tag, " mem_wdata"}, mem_req_wdata_o, 0);
        checkOutput({tag, " mem_wmask"}, mem_req_wmask_o, 0);
        checkOutput({tag, " ifu_rsp"}, {ifu_rsp_valid_o, ifu_rsp_err_o, ifu_rsp_data_o}, 0);
        checkOutput({tag, " lsu_rsp"}, {lsu_rsp_valid_o, lsu_rsp_err_o, lsu_rsp_data_o}, 0);
        checkOutput({tag, " busy"}, busy_o, 0);
    endtask

    initial begin
        arb_vec_t arb_tab[4];
        bit       starve_lsu[10];
        arb_tab[0] = '{iv: 0, lv: 0, exp_ir: 0, exp_lr: 0};
        arb_tab[1] = '{iv: 1, lv: 0, exp_ir: 1, exp_lr: 0};
        arb_tab[2] = '{iv: 0, lv: 1, exp_ir: 0, exp_lr: 1};
        arb_tab[3] = '{iv: 1, lv: 1, exp_ir: 0, exp_lr: 1};
        starve_lsu = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        rst = 1'b1;
        applyStimulus(0, '0, 0, '0, 0, '0, '0);
        mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_data_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        tick();
        rst = 1'b0;

        // Arbitration table: valids withdrawn before the edge so nothing is accepted.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(arb_tab[i].iv, 32'h8000_0040, arb_tab[i].lv, 32'h8000_0080, 0, '0, '0);
            @(negedge clk);
            checkOutput($sformatf("arb vec%0d ifu_ready", i), ifu_req_ready_o, arb_tab[i].exp_ir);
            checkOutput($sformatf("arb vec%0d lsu_ready", i), lsu_req_ready_o, arb_tab[i].exp_lr);
            #1 applyStimulus(0, '0, 0, '0, 0, '0, '0);
            tick();
        end

        $display("[TB] single fetch");
        mem_req_ready_i = 1'b1;
        applyStimulus(1, 32'h8000_0000, 0, '0, 0, '0, '0);
        @(negedge clk);
        checkOutput("fetch ifu_ready", ifu_req_ready_o, 1);
        tick();
        applyStimulus(0, '0, 0, '0, 0, '0, '0);
        @(negedge clk);
        checkOutput("fetch mem_valid", mem_req_valid_o, 1);
        checkOutput("fetch mem_addr", mem_req_addr_o, 32'h8000_0000);
        checkOutput("fetch mem_wen", mem_req_wen_o, 0);
        checkOutput("fetch mem_wmask", mem_req_wmask_o, 0);
        checkOutput("fetch busy", busy_o, 1);
        tick();
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0000_0413;
        @(negedge clk);
        checkOutput("fetch wait mem_valid", mem_req_valid_o, 0);
        checkOutput("fetch early pulse", ifu_rsp_valid_o, 0);
        tick();
        mem_rsp_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("fetch rsp_valid", ifu_rsp_valid_o, 1);
        checkOutput("fetch rsp_data", ifu_rsp_data_o, 32'h0000_0413);
        checkOutput("fetch rsp_err", ifu_rsp_err_o, 0);
        checkOutput("fetch lsu_rsp_valid", lsu_rsp_valid_o, 0);
        checkOutput("fetch busy end", busy_o, 0);
        tick();
        @(negedge clk);
        checkOutput("fetch pulse width", ifu_rsp_valid_o, 0);

        $display("[TB] simultaneous requests");
        tick();
        applyStimulus(1, 32'h8000_0004, 1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        checkOutput("simul grant", {ifu_req_ready_o, lsu_req_ready_o}, 2'b01);
        tick();
        applyStimulus(1, 32'h8000_0004, 0, '0, 0, '0, '0);
        @(negedge clk);
        checkOutput("simul store addr", mem_req_addr_o, 32'h8000_1000);
        checkOutput("simul store fields", {mem_req_wen_o, mem_req_wdata_o, mem_req_wmask_o},
                    {1'b1, 32'hDEAD_BEEF, 4'hF});
        checkOutput("simul req ready", {ifu_req_ready_o, lsu_req_ready_o}, 2'b00);
        serveTxn(32'h0);
        @(negedge clk);
        checkOutput("simul store rsp", {lsu_rsp_valid_o, lsu_rsp_err_o, ifu_rsp_valid_o}, 3'b100);
        checkOutput("simul ifu next", ifu_req_ready_o, 1);
        tick();
        applyStimulus(0, '0, 0, '0, 0, '0, '0);
        serveTxn(32'h0000_0013);
        @(negedge clk);
        checkOutput("simul ifu rsp", {ifu_rsp_valid_o, ifu_rsp_data_o}, {1'b1, 32'h0000_0013});

        $display("[TB] starvation guard");
        tick();
        applyStimulus(1, 32'h8000_0100, 1, 32'h8000_0200, 0, '0, '0);
        for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            checkOutput($sformatf("starve grant %0d", g), {ifu_req_ready_o, lsu_req_ready_o},
                        starve_lsu[g] ? 2'b01 : 2'b10);
            tick();
            serveTxn(32'h100 + g);
        end
        applyStimulus(0, '0, 0, '0, 0, '0, '0);

        $display("[TB] timeout");
        applyStimulus(0, '0, 1, 32'h8000_2000, 0, '0, '0);
        @(negedge clk);
        checkOutput("timeout lsu_ready", lsu_req_ready_o, 1);
        tick();
        applyStimulus(0, '0, 0, '0, 0, '0, '0);
        tick();
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            checkOutput($sformatf("timeout wait%0d busy", k), busy_o, 1);
            checkOutput($sformatf("timeout wait%0d no pulse", k), lsu_rsp_valid_o, 0);
            tick();
        end
        @(negedge clk);
        checkOutput("timeout pulse", {lsu_rsp_valid_o, lsu_rsp_err_o, lsu_rsp_data_o},
                    {1'b1, 1'b1, 32'h0});
        checkOutput("timeout busy drop", busy_o, 0);
        checkOutput("timeout ifu quiet", ifu_rsp_valid_o, 0);

        $display("[TB] response/timeout collision");
        tick();
        applyStimulus(0, '0, 1, 32'h8000_2004, 0, '0, '0);
        tick();
        applyStimulus(0, '0, 0, '0, 0, '0, '0);
        tick();
        repeat (TO - 1) tick();
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h1234_5678;
        @(negedge clk);
        checkOutput("collide busy", busy_o, 1);
        tick();
        mem_rsp_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("collide pulse", {lsu_rsp_valid_o, lsu_rsp_err_o, lsu_rsp_data_o},
                    {1'b1, 1'b0, 32'h1234_5678});

        $display("[TB] stray response");
        tick();
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'hFFFF_0000;
        @(negedge clk);
        checkOutput("stray busy", busy_o, 0);
        tick();
        mem_rsp_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("stray pulses", {ifu_rsp_valid_o, lsu_rsp_valid_o, busy_o, mem_req_valid_o}, 0);
        checkOutput("stray data held", lsu_rsp_data_o, 32'h1234_5678);

        $display("[TB] reset during wait");
        tick();
        applyStimulus(1, 32'h8000_3000, 0, '0, 0, '0, '0);
        tick();
        applyStimulus(0, '0, 0, '0, 0, '0, '0);
        tick();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("mid reset");
        tick();
        rst = 1'b0;
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h7777_7777;
        @(negedge clk);
        checkOutput("post reset idle", {busy_o, ifu_rsp_valid_o}, 0);
        tick();
        mem_rsp_valid_i = 1'b0;
        @(negedge clk);
        checkOutput("post reset no pulse", {ifu_rsp_valid_o, lsu_rsp_valid_o}, 0);
        tick();
        applyStimulus(1, 32'h8000_3004, 0, '0, 0, '0, '0);
        @(negedge clk);
        checkOutput("post reset grant", ifu_req_ready_o, 1);
        tick();
        applyStimulus(0, '0, 0, '0, 0, '0, '0);
        @(negedge clk);
        checkOutput("post reset addr", mem_req_addr_o, 32'h8000_3004);
        serveTxn(32'h0000_CAFE);
        @(negedge clk);
        checkOutput("post reset rsp", {ifu_rsp_valid_o, ifu_rsp_err_o, ifu_rsp_data_o},
                    {1'b1, 1'b0, 32'h0000_CAFE});

        $display("[TB] random traffic");
        tick();
        rst = 1'b1;
        applyStimulus(0, '0, 0, '0, 0, '0, '0);
        mem_req_ready_i = 0; mem_rsp_valid_i = 0;
        tick();
        tick();
        rst = 1'b0;
        modelReset();
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 99) < 60, $urandom(),
                          $urandom_range(0, 99) < 55, $urandom(), $urandom_range(0, 1),
                          $urandom(), MW'($urandom()));
            mem_req_ready_i = $urandom_range(0, 99) < 60;
            mem_rsp_valid_i = $urandom_range(0, 99) < 25;
            mem_rsp_data_i  = $urandom();
            @(negedge clk);
            modelStep();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
